// File: rtl/memx_write_arbiter.sv
// memx_write_arbiter
//   Two-client burst write arbiter in front of a single memX write port.
//   In IDLE a requesting client is granted (round-robin on ties), its base
//   address and beat count are latched, and its write beats are then
//   forwarded to memX one cycle after acceptance. Beats that land past the
//   last valid memX word are consumed but not written, and set a sticky err.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   a_req/b_req          : burst request per client
//   a_base/b_base        : burst start address (sampled at grant)
//   a_len/b_len          : burst beat count (sampled at grant)
//   a_valid/b_valid      : write beat valid
//   a_data/b_data        : write beat data
//   a_ready/b_ready      : beat accepted when valid & ready
//   a_done/b_done        : one-cycle burst-complete pulse
//   mem_we/mem_waddr/mem_wdata : memX write port (registered)
//   busy                 : high while a burst is granted
//   err                  : sticky out-of-range flag
module memx_write_arbiter #(
    parameter int element_width = 64,
    parameter int no_of_units   = 8,
    parameter int address_width = 20,
    parameter int mem_depth     = 1001,
    parameter int len_width     = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   a_req,
    input  logic                                   b_req,
    input  logic [address_width-1:0]               a_base,
    input  logic [address_width-1:0]               b_base,
    input  logic [len_width-1:0]                   a_len,
    input  logic [len_width-1:0]                   b_len,
    input  logic                                   a_valid,
    input  logic                                   b_valid,
    input  logic [no_of_units*element_width-1:0]   a_data,
    input  logic [no_of_units*element_width-1:0]   b_data,
    output logic                                   a_ready,
    output logic                                   b_ready,
    output logic                                   a_done,
    output logic                                   b_done,
    output logic                                   mem_we,
    output logic [address_width-1:0]               mem_waddr,
    output logic [no_of_units*element_width-1:0]   mem_wdata,
    output logic                                   busy,
    output logic                                   err
);

    localparam int AW = address_width;
    localparam int LW = len_width;
    localparam int W  = no_of_units * element_width;
    localparam logic [AW-1:0] MAX_ADDR = AW'(mem_depth - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  base_q, base_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic           last_b_q, last_b_d;
    logic           a_done_q, a_done_d;
    logic           b_done_q, b_done_d;
    logic           mem_we_q, mem_we_d;
    logic [AW-1:0]  mem_waddr_q, mem_waddr_d;
    logic [W-1:0]   mem_wdata_q, mem_wdata_d;
    logic           err_q, err_d;

    logic           pick_b;
    logic [LW-1:0]  sel_len;
    logic           beat;
    logic [AW-1:0]  beat_addr;
    logic           in_range;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        last_b_d    = last_b_q;
        a_done_d    = 1'b0;
        b_done_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        pick_b      = 1'b0;
        sel_len     = '0;
        beat        = 1'b0;
        beat_addr   = base_q + AW'(cnt_q);
        in_range    = (beat_addr <= MAX_ADDR);

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    // B wins only when alone or when A was served last.
                    pick_b   = b_req && (!a_req || !last_b_q);
                    sel_len  = pick_b ? b_len : a_len;
                    last_b_d = pick_b;
                    base_d   = pick_b ? b_base : a_base;
                    len_d    = sel_len;
                    cnt_d    = '0;
                    // Zero-length bursts complete straight from IDLE.
                    if (sel_len == '0) begin
                        a_done_d = !pick_b;
                        b_done_d = pick_b;
                    end else begin
                        state_d = pick_b ? GRANT_B : GRANT_A;
                    end
                end
            end
            GRANT_A, GRANT_B: begin
                beat = (state_q == GRANT_A) ? a_valid : b_valid;
                if (beat) begin
                    // Out-of-range beats are consumed but never reach memX.
                    mem_we_d = in_range;
                    if (in_range) begin
                        mem_waddr_d = beat_addr;
                        mem_wdata_d = (state_q == GRANT_A) ? a_data : b_data;
                    end else begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_d == len_q) begin
                        state_d  = IDLE;
                        a_done_d = (state_q == GRANT_A);
                        b_done_d = (state_q == GRANT_B);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            last_b_q    <= 1'b1;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            last_b_q    <= last_b_d;
            a_done_q    <= a_done_d;
            b_done_q    <= b_done_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    assign a_ready   = (state_q == GRANT_A);
    assign b_ready   = (state_q == GRANT_B);
    assign busy      = (state_q != IDLE);
    assign a_done    = a_done_q;
    assign b_done    = b_done_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule
